// File: rtl/osd_ram_write_arbiter.sv
// OSD character RAM write-port arbiter: I2C writes always win over the internal clear/fill engine.
// Optional build macro OSD_FILL_ABORT_EN adds the fill_abort input.
module osd_ram_write_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i2c_wren,
  input  logic [ADDR_W-1:0] i2c_wraddress,
  input  logic [DATA_W-1:0] i2c_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_char,
`ifdef OSD_FILL_ABORT_EN
  input  logic              fill_abort,
`endif
  output logic              fill_busy,
  output logic              fill_done,
  output logic [7:0]        stall_count,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_dataIn
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] char_q;
  logic              abort_now;
  logic              last_cell;
  logic [ADDR_W-1:0] fill_addr;

  always_comb begin
`ifdef OSD_FILL_ABORT_EN
    abort_now = (state == S_FILL) && fill_abort;
`else
    abort_now = 1'b0;
`endif
    // Address arithmetic is ADDR_W bits wide so the fill wraps from the top cell to 0.
    fill_addr = base_q + cnt_q[ADDR_W-1:0];
    last_cell = (cnt_q == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      char_q        <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      stall_count   <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_dataIn    <= '0;
    end else begin
      fill_done <= 1'b0;
      ram_wren  <= 1'b0;

      if (i2c_wren) begin
        ram_wren      <= 1'b1;
        ram_wraddress <= i2c_wraddress;
        ram_dataIn    <= i2c_data;
      end else if (state == S_FILL && !abort_now) begin
        ram_wren      <= 1'b1;
        ram_wraddress <= fill_addr;
        ram_dataIn    <= char_q;
      end

      case (state)
        S_IDLE: begin
          if (fill_start) begin
            if (fill_len != '0) begin
              base_q    <= fill_base;
              len_q     <= fill_len;
              char_q    <= fill_char;
              cnt_q     <= '0;
              state     <= S_FILL;
              fill_busy <= 1'b1;
            end else begin
              fill_done <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (abort_now) begin
            state     <= S_DONE;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
          end else if (i2c_wren) begin
            if (stall_count != 8'hFF) stall_count <= stall_count + 8'd1;
          end else begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (last_cell) begin
              state     <= S_DONE;
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_ram_write_arbiter.sv
// Bench for osd_ram_write_arbiter: directed scenarios plus randomized fills against a write-list model.
// Define OSD_FILL_ABORT_EN to also exercise fill_abort.
module tb_osd_ram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i2c_wren;
  logic [9:0]  i2c_wraddress;
  logic [7:0]  i2c_data;
  logic        fill_start;
  logic [9:0]  fill_base;
  logic [10:0] fill_len;
  logic [7:0]  fill_char;
`ifdef OSD_FILL_ABORT_EN
  logic        fill_abort;
`endif
  logic        fill_busy;
  logic        fill_done;
  logic [7:0]  stall_count;
  logic        ram_wren;
  logic [9:0]  ram_wraddress;
  logic [7:0]  ram_dataIn;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned model_stalls = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  always #5 clk = ~clk;

  osd_ram_write_arbiter #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i2c_wren      (i2c_wren),
    .i2c_wraddress (i2c_wraddress),
    .i2c_data      (i2c_data),
    .fill_start    (fill_start),
    .fill_base     (fill_base),
    .fill_len      (fill_len),
    .fill_char     (fill_char),
`ifdef OSD_FILL_ABORT_EN
    .fill_abort    (fill_abort),
`endif
    .fill_busy     (fill_busy),
    .fill_done     (fill_done),
    .stall_count   (stall_count),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_dataIn    (ram_dataIn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i2c_wren   = 1'b0;
    fill_start = 1'b0;
`ifdef OSD_FILL_ABORT_EN
    fill_abort = 1'b0;
`endif
  endtask

  // Expected RAM write list: each FILL cycle carries either an I2C write (stall) or the next fill cell.
  task automatic run_fill(input string tag, input logic [9:0] base, input logic [10:0] len,
                          input logic [7:0] ch, input int unsigned pct,
                          input logic [31:0] force_mask, input bit i2c_at_start);
    logic        stall_at[$];
    logic [9:0]  ia[$];
    logic [7:0]  id[$];
    int unsigned fills, stalls, total, busy_n, done_n, done_at, k, nmin;
    logic        st;
    logic [9:0]  a;
    logic [7:0]  d;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    idle_inputs();
    fill_start = 1'b1;
    fill_base  = base;
    fill_len   = len;
    fill_char  = ch;
    if (i2c_at_start) begin
      a = 10'($urandom);
      d = 8'($urandom);
      i2c_wren = 1'b1; i2c_wraddress = a; i2c_data = d;
      exp_q.push_back({a, d});
    end
    fills = 0; stalls = 0;
    while (fills < 32'(len)) begin
      k  = stall_at.size() + 1;
      st = 1'b0;
      if (k <= 32) st = force_mask[k-1];
      if ($urandom_range(99) < pct) st = 1'b1;
      if (st) begin
        a = 10'($urandom);
        d = 8'($urandom);
        ia.push_back(a); id.push_back(d);
        exp_q.push_back({a, d});
        stalls++;
      end else begin
        ia.push_back('0); id.push_back('0);
        exp_q.push_back({base + 10'(fills), ch});
        fills++;
      end
      stall_at.push_back(st);
    end
    total = 32'(len) + stalls;
    model_stalls = (model_stalls + stalls > 255) ? 255 : model_stalls + stalls;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int unsigned c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      if (ram_wren) obs_q.push_back({ram_wraddress, ram_dataIn});
      if (fill_busy) busy_n++;
      if (fill_done) begin done_n++; done_at = c; end
      idle_inputs();
      // Stray fill_start requests while busy or in DONE must be ignored.
      if (c <= total + 1) begin
        fill_start = ($urandom_range(2) == 0);
        fill_base  = 10'($urandom);
        fill_len   = 11'($urandom_range(1, 1024));
        fill_char  = 8'($urandom);
      end
      if (c <= total && stall_at[c-1]) begin
        i2c_wren = 1'b1; i2c_wraddress = ia[c-1]; i2c_data = id[c-1];
      end
    end
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < nmin; i++) check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_busy_cycles"}, busy_n, total);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_cycle"}, done_at, total + 1);
    check({tag, "_stall_count"}, 32'(stall_count), model_stalls);
  endtask

  initial begin
    int unsigned wr_n, done_n, done_at, busy_n;
    logic [9:0]  last_addr;

    reset_n = 1'b0;
    idle_inputs();
    i2c_wraddress = '0; i2c_data = '0;
    fill_base = '0; fill_len = '0; fill_char = '0;
    repeat (3) @(negedge clk);
    check("rst_wren", 32'(ram_wren), 0);
    check("rst_addr", 32'(ram_wraddress), 0);
    check("rst_data", 32'(ram_dataIn), 0);
    check("rst_busy", 32'(fill_busy), 0);
    check("rst_done", 32'(fill_done), 0);
    check("rst_stall", 32'(stall_count), 0);
    reset_n = 1'b1;

    @(negedge clk);
    i2c_wren = 1'b1; i2c_wraddress = 10'h005; i2c_data = 8'h41;
    @(negedge clk);
    idle_inputs();
    check("i2c_wren", 32'(ram_wren), 1);
    check("i2c_addr", 32'(ram_wraddress), 32'h005);
    check("i2c_data", 32'(ram_dataIn), 32'h41);
    @(negedge clk);
    check("i2c_wren_off", 32'(ram_wren), 0);
    check("i2c_addr_hold", 32'(ram_wraddress), 32'h005);
    check("i2c_data_hold", 32'(ram_dataIn), 32'h41);

    run_fill("full", 10'h000, 11'd1024, 8'h20, 0, 32'h0, 1'b0);
    run_fill("wrap", 10'h3FE, 11'd4, 8'h5A, 0, 32'h0, 1'b0);
    run_fill("stall8", 10'h040, 11'd8, 8'h33, 0, 32'h6, 1'b0);
    run_fill("samecyc", 10'h200, 11'd5, 8'h11, 0, 32'h0, 1'b1);

    @(negedge clk);
    idle_inputs();
    fill_start = 1'b1; fill_len = '0; fill_base = 10'h123; fill_char = 8'hEE;
    @(negedge clk);
    idle_inputs();
    check("len0_done", 32'(fill_done), 1);
    check("len0_busy", 32'(fill_busy), 0);
    check("len0_wren", 32'(ram_wren), 0);
    @(negedge clk);
    check("len0_done_off", 32'(fill_done), 0);
    check("len0_wren_off", 32'(ram_wren), 0);

    for (int unsigned r = 0; r < 6; r++)
      run_fill("rand", 10'($urandom), 11'($urandom_range(1, 120)), 8'($urandom), 30, 32'h0,
               1'($urandom_range(1)));
    run_fill("sat", 10'($urandom), 11'd300, 8'h7E, 60, 32'h0, 1'b0);

`ifdef OSD_FILL_ABORT_EN
    @(negedge clk);
    idle_inputs();
    fill_start = 1'b1; fill_base = 10'h100; fill_len = 11'd20; fill_char = 8'h55;
    wr_n = 0; done_n = 0; done_at = 0; busy_n = 0; last_addr = '0;
    for (int unsigned c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ram_wren) begin wr_n++; last_addr = ram_wraddress; end
      if (fill_done) begin done_n++; done_at = c; end
      if (fill_busy) busy_n++;
      idle_inputs();
      fill_abort = (c == 4);
    end
    check("abort_nwrites", wr_n, 3);
    check("abort_last_addr", 32'(last_addr), 32'h102);
    check("abort_done_count", done_n, 1);
    check("abort_done_cycle", done_at, 5);
    check("abort_busy_cycles", busy_n, 4);
`endif

    @(negedge clk);
    idle_inputs();
    fill_start = 1'b1; fill_base = 10'h010; fill_len = 11'd50; fill_char = 8'h77;
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_wren", 32'(ram_wren), 0);
    check("midrst_addr", 32'(ram_wraddress), 0);
    check("midrst_data", 32'(ram_dataIn), 0);
    check("midrst_busy", 32'(fill_busy), 0);
    check("midrst_done", 32'(fill_done), 0);
    check("midrst_stall", 32'(stall_count), 0);
    model_stalls = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wr_n = 0; done_n = 0; busy_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_wren) wr_n++;
      if (fill_done) done_n++;
      if (fill_busy) busy_n++;
    end
    check("midrst_after_writes", wr_n, 0);
    check("midrst_after_done", done_n, 0);
    check("midrst_after_busy", busy_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
